// File: rtl/icache_pkg.sv
// icache_pkg: shared types and constants for the instruction cache.
// No ports: FSM states, address-field width helpers, NOP word.
package icache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int word_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int tag_w(
        input int addr_w,
        input int num_lines,
        input int words
    );
        return addr_w - 2 - $clog2(num_lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/icache_line_ram.sv
// icache_line_ram: NUM_LINES x WORDS_PER_LINE word store.
// Ports: clk; we/wline/wword/wdata sync write; rline/rword/rdata async read.
module icache_line_ram
    import icache_pkg::*;
#(
    parameter  int NUM_LINES      = 16,
    parameter  int WORDS_PER_LINE = 4,
    localparam int IDX_W          = idx_w(NUM_LINES),
    localparam int WORD_W         = word_w(WORDS_PER_LINE)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  wline,
    input  logic [WORD_W-1:0] wword,
    input  logic [31:0]       wdata,
    input  logic [IDX_W-1:0]  rline,
    input  logic [WORD_W-1:0] rword,
    output logic [31:0]       rdata
);

    localparam int DEPTH = NUM_LINES * WORDS_PER_LINE;

    logic [31:0] mem [DEPTH];

    // Contents are undefined until a line is refilled;
    // the valid bits gate every read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wline, wword}] <= wdata;
        end
    end

    assign rdata = mem[{rline, rword}];

endmodule

// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped read-only I-cache for the fetch stage.
// Ports: clk, reset(async low), pc -> instr/stall, inv pulse,
// mem_req/mem_addr/mem_ack/mem_rdata single-beat refill bus.
// ICACHE_STATS_EN adds hit_count/miss_count outputs.
module icache_fetch
    import icache_pkg::*;
#(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr,
    output logic              stall,
    input  logic              inv,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int IDX_W  = idx_w(NUM_LINES);
    localparam int WORD_W = word_w(WORDS_PER_LINE);
    localparam int TAG_W  = tag_w(ADDR_W, NUM_LINES, WORDS_PER_LINE);
    localparam int LINE_LSB = WORD_W + 2;

    localparam logic [WORD_W-1:0] LAST_BEAT =
        WORD_W'(WORDS_PER_LINE - 1);

    logic [WORD_W-1:0] pc_word;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic [ADDR_W-1:0] pc_base;
    logic              unused_off;

    assign pc_word    = pc[2 +: WORD_W];
    assign pc_idx     = pc[LINE_LSB +: IDX_W];
    assign pc_tag     = pc[ADDR_W-1 -: TAG_W];
    assign pc_base    = {pc[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
    assign unused_off = ^pc[1:0];

    state_t            state;
    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]  tags [NUM_LINES];
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic [WORD_W-1:0] cnt;
    logic              inv_pending;

    logic        hit;
    logic        beat;
    logic        last_beat;
    logic [31:0] rdata;

    assign hit       = valid[pc_idx] && (tags[pc_idx] == pc_tag);
    assign beat      = mem_req && mem_ack;
    assign last_beat = beat && (cnt == LAST_BEAT);

    assign stall = (state != IDLE) || !hit;
    assign instr = (state == IDLE && hit) ? rdata : NOP_INSTR;

    icache_line_ram #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_ram (
        .clk   (clk),
        .we    (beat),
        .wline (fill_idx),
        .wword (cnt),
        .wdata (mem_rdata),
        .rline (pc_idx),
        .rword (pc_word),
        .rdata (rdata)
    );

    // Tags need no reset: a line is only trusted once valid is set.
    always_ff @(posedge clk) begin
        if (last_beat) begin
            tags[fill_idx] <= fill_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            valid       <= '0;
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            inv_pending <= 1'b0;
            fill_idx    <= '0;
            fill_tag    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    inv_pending <= 1'b0;
                    if (inv) begin
                        valid <= '0;
                    end else if (!hit) begin
                        state    <= REFILL;
                        fill_idx <= pc_idx;
                        fill_tag <= pc_tag;
                        cnt      <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= pc_base;
                    end
                end
                REFILL: begin
                    if (inv) begin
                        inv_pending <= 1'b1;
                    end
                    if (beat) begin
                        cnt <= cnt + WORD_W'(1);
                        if (cnt == LAST_BEAT) begin
                            // An inv seen during this refill
                            // leaves the new line invalid.
                            valid[fill_idx] <= ~(inv_pending | inv);
                            mem_req         <= 1'b0;
                            inv_pending     <= 1'b0;
                            state           <= IDLE;
                        end else begin
                            mem_addr <= mem_addr + ADDR_W'(4);
                        end
                    end
                    // Later assignment wins over the line set above.
                    if (inv) begin
                        valid <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE) begin
            if (hit) begin
                hit_count <= hit_count + 32'd1;
            end else if (!inv) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// tb_icache_fetch: randomized scoreboard bench for icache_fetch.
// Driver pushes expectations from a line-level cache model.
module tb_icache_fetch;

    localparam int NL  = 16;
    localparam int WPL = 4;
    localparam int WW  = 2;
    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        stall;
    logic        inv;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    icache_fetch #(
        .NUM_LINES      (NL),
        .WORDS_PER_LINE (WPL),
        .ADDR_W         (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .instr      (instr),
        .stall      (stall),
        .inv        (inv),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        bit          hit;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] beat_q[$];

    int checks = 0;
    int passed = 0;

    bit          mvalid[NL];
    int unsigned mline[NL];

    int cyc        = 0;
    int last_ack   = -1;
    int acks       = 0;
    int refills    = 0;
    int fetches    = 0;
    int accept_cnt = 0;
    int mode       = 0;
    bit sb_en      = 1'b0;
    bit inv_mid_arm = 1'b0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
    endfunction

    // Memory responder: one call per cycle, just after posedge.
    task automatic step();
        bit a;
        @(posedge clk);
        #1;
        cyc++;
        inv       = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (mem_req) begin
            case (mode)
                0:       a = 1'b1;
                1:       a = (cyc % 3 == 0);
                default: a = ($urandom_range(0, 1) == 1);
            endcase
            if (inv_mid_arm && mem_addr[WW+1:2] == 2'd1) begin
                inv         = 1'b1;
                inv_mid_arm = 1'b0;
            end
            if (a) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr ^ KEY;
                last_ack  = cyc;
                acks++;
                if (sb_en) begin
                    if (beat_q.size() == 0)
                        $display("FAIL mem_addr: got %h expected none",
                                 mem_addr);
                    else
                        check("mem_addr", mem_addr, beat_q.pop_front());
                    if (beat_q.size() == 0 && mem_addr === 32'hx)
                        checks++;
                end
            end
        end else if (mode == 2) begin
            mem_ack = ($urandom_range(0, 1) == 1);
        end
    endtask

    // Predict the fetch outcome at line granularity and present pc.
    task automatic issue(logic [31:0] a, bit inv_f, bit inv_m, int md);
        int unsigned line;
        int          idx;
        int          n;
        bit          h;
        exp_t        e;
        line    = a >> (2 + WW);
        idx     = int'(line % NL);
        h       = mvalid[idx] && (mline[idx] == line);
        n       = inv_m ? 2 : 1;
        e.instr = {a[31:2], 2'b00} ^ KEY;
        e.hit   = h;
        e.lat   = 1;
        if (h) begin
            if (inv_f) model_clear();
        end else begin
            if (inv_f || inv_m) model_clear();
            for (int r = 0; r < n; r++)
                for (int w = 0; w < WPL; w++)
                    beat_q.push_back((line * WPL + w) * 4);
            mvalid[idx] = 1'b1;
            mline[idx]  = line;
            refills    += n;
            e.lat = (md == 0) ? 1 + n * (WPL + 1) + int'(inv_f) : 0;
        end
        mode        = md;
        inv_mid_arm = inv_m && !h;
        exp_q.push_back(e);
        sb_en = 1'b1;
        pc    = a;
        inv   = inv_f;
        fetches++;
    endtask

    task automatic fetch(logic [31:0] a, bit inv_f, bit inv_m, int md);
        do step(); while (accept_cnt < fetches);
        issue(a, inv_f, inv_m, md);
    endtask

    // Monitor: pops one expectation per accepted (stall=0) cycle.
    initial begin
        int   cnt;
        exp_t e;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (sb_en && reset) begin
                cnt++;
                if (!stall) begin
                    if (exp_q.size() == 0) begin
                        $display("FAIL accept: got unexpected %h", instr);
                        checks++;
                    end else begin
                        e = exp_q.pop_front();
                        check("instr", instr, e.instr);
                        check("hit", 32'(cnt == 1), 32'(e.hit));
                        if (e.lat != 0)
                            check("latency", 32'(cnt), 32'(e.lat));
                        if (!e.hit)
                            check("ack_to_accept", 32'(cyc),
                                  32'(last_ack + 1));
                    end
                    cnt = 0;
                    accept_cnt++;
                end else begin
                    check("nop_on_stall", instr, 32'h0);
                    if (cnt > 300) begin
                        $display("FAIL timeout: got stall after %0d cycles expected accept", cnt);
                        $fatal(1, "timeout");
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int a0;
        pc        = 32'h0;
        inv       = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        reset     = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_stall", 32'(stall), 32'h1);
        check("rst_instr", instr, 32'h0);

        step();
        reset = 1'b1;
        issue(32'h000, 1'b0, 1'b0, 0);
        fetch(32'h008, 1'b0, 1'b0, 0);
        fetch(32'h100, 1'b0, 1'b0, 0);
        fetch(32'h000, 1'b0, 1'b0, 0);
        fetch(32'h204, 1'b0, 1'b0, 1);
        fetch(32'h308, 1'b0, 1'b1, 0);
        fetch(32'h30C, 1'b0, 1'b0, 0);
        fetch(32'h414, 1'b1, 1'b0, 0);
        fetch(32'h208, 1'b1, 1'b0, 0);
        fetch(32'h208, 1'b0, 1'b0, 2);
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 3)) * 32'h100
              + 32'($urandom_range(0, 63)) * 32'd4
              + 32'($urandom_range(0, 3));
            fetch(a, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 2));
        end
        do step(); while (accept_cnt < fetches);
        sb_en = 1'b0;
        mode  = 0;
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        check("beat_q_drained", 32'(beat_q.size()), 32'h0);

        repeat (3) step();
`ifdef ICACHE_STATS_EN
        @(negedge clk);
        check("hit_count", hit_count, 32'(fetches + 3));
        check("miss_count", miss_count, 32'(refills));
`endif

        // Reset in the middle of a refill.
        pc = 32'h700;
        a0 = acks;
        n  = 0;
        do begin step(); n++; end while (acks < a0 + 2 && n < 50);
        check("two_beats", 32'(acks - a0), 32'h2);
        @(negedge clk);
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_req", 32'(mem_req), 32'h1);
        reset = 1'b0;
        #1;
        check("async_req_drop", 32'(mem_req), 32'h0);
        check("async_addr_clr", mem_addr, 32'h0);
        step();
        step();
        pc    = 32'h0;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_miss", 32'(stall), 32'h1);
        check("post_rst_idle", 32'(mem_req), 32'h0);
        step();
        check("post_rst_req", 32'(mem_req), 32'h1);
        check("post_rst_addr", mem_addr, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
